// File: rtl/prog_tick_pkg.sv
// Shared definitions for the programmable tick generator: unit encodings,
// per-channel state type and the cycles-per-unit helper.
package prog_tick_pkg;

  localparam logic [1:0] UNIT_CLK = 2'b00;
  localparam logic [1:0] UNIT_US  = 2'b01;
  localparam logic [1:0] UNIT_MS  = 2'b10;
  localparam logic [1:0] UNIT_S   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } chan_state_e;

  function automatic int unsigned cycles_per_unit(input logic [1:0]  unit_sel,
                                                  input int unsigned clk_freq_mhz);
    int unsigned cycles;
    case (unit_sel)
      UNIT_CLK: cycles = 1;
      UNIT_US:  cycles = clk_freq_mhz;
      UNIT_MS:  cycles = 1000 * clk_freq_mhz;
      default:  cycles = 1000000 * clk_freq_mhz;
    endcase
    return cycles;
  endfunction

endpackage

// File: rtl/prog_tick_chan.sv
// One tick-generator channel: prescaler + unit counter with shadowed period/unit.
// One-shot completion is compiled in only when PROG_TICK_ONESHOT_EN is defined.
module prog_tick_chan
  import prog_tick_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int PERIOD_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          unit,
  input  logic                oneshot,
  input  logic                sync,
  output logic                clk_o,
  output logic                tick_o,
  output logic                done_o,
  output chan_state_e         state_o
);

  localparam int PRESC_W = $clog2(1000000 * CLK_FREQ_MHZ);

  chan_state_e         state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d, presc_last;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [1:0]          unit_q, unit_d;
  logic                clk_q, clk_d, tick_q, tick_d, done_q, done_d;
  logic                load;
  logic [PERIOD_W:0]   half_d;

`ifdef PROG_TICK_ONESHOT_EN
  logic os_q, os_d;

  always_ff @(posedge clk) begin
    if (rst) os_q <= 1'b0;
    else     os_q <= os_d;
  end
`else
  logic unused_oneshot;
  assign unused_oneshot = oneshot;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      unit_q  <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      unit_q  <= unit_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // load marks a sampling point: RUN entry, sync restart or a period start.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    unit_d     = unit_q;
    load       = 1'b0;
    presc_last = PRESC_W'(cycles_per_unit(unit_q, CLK_FREQ_MHZ) - 1);
`ifdef PROG_TICK_ONESHOT_EN
    os_d       = os_q;
`endif
    if (!en) begin
      state_d = ST_IDLE;
      presc_d = '0;
      cnt_d   = '0;
      per_d   = '0;
      unit_d  = '0;
`ifdef PROG_TICK_ONESHOT_EN
      os_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: load = (period != '0);
        ST_RUN: begin
          if (sync) begin
            load = 1'b1;
          end else if (presc_q == presc_last) begin
            presc_d = '0;
            if (cnt_q == per_q - PERIOD_W'(1)) begin
`ifdef PROG_TICK_ONESHOT_EN
              if (os_q) begin
                state_d = ST_DONE;
                cnt_d   = '0;
              end else begin
                load = 1'b1;
              end
`else
              load = 1'b1;
`endif
            end else begin
              cnt_d = cnt_q + PERIOD_W'(1);
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
`ifdef PROG_TICK_ONESHOT_EN
        default: state_d = state_q;
`else
        default: state_d = ST_IDLE;
`endif
      endcase
      if (load) begin
        presc_d = '0;
        cnt_d   = '0;
        per_d   = period;
        unit_d  = unit;
        state_d = (period != '0) ? ST_RUN : ST_IDLE;
`ifdef PROG_TICK_ONESHOT_EN
        os_d    = oneshot;
`endif
      end
    end
  end

  // Outputs are registered from the next position so they align with the state.
  always_comb begin
    half_d = ({1'b0, per_d} + (PERIOD_W+1)'(1)) >> 1;
    tick_d = load && (state_d == ST_RUN);
    clk_d  = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_d);
`ifdef PROG_TICK_ONESHOT_EN
    done_d = (state_d == ST_DONE);
`else
    done_d = 1'b0;
`endif
  end

  assign clk_o   = clk_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/prog_tick_gen.sv
// Multi-channel programmable tick generator; NCH independent prog_tick_chan
// instances sharing one sync strobe. One-shot mode needs PROG_TICK_ONESHOT_EN.
module prog_tick_gen
  import prog_tick_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int NCH          = 4,
  parameter int PERIOD_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          en,
  input  logic [NCH*PERIOD_W-1:0] period,
  input  logic [2*NCH-1:0]        unit,
  input  logic [NCH-1:0]          oneshot,
  input  logic                    sync,
  output logic [NCH-1:0]          clk_o,
  output logic [NCH-1:0]          tick_o,
  output logic [NCH-1:0]          done_o,
  output logic [2*NCH-1:0]        state_o
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    chan_state_e chan_state;

    prog_tick_chan #(
      .CLK_FREQ_MHZ (CLK_FREQ_MHZ),
      .PERIOD_W     (PERIOD_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .period  (period[i*PERIOD_W +: PERIOD_W]),
      .unit    (unit[2*i +: 2]),
      .oneshot (oneshot[i]),
      .sync    (sync),
      .clk_o   (clk_o[i]),
      .tick_o  (tick_o[i]),
      .done_o  (done_o[i]),
      .state_o (chan_state)
    );

    assign state_o[2*i +: 2] = chan_state;
  end

endmodule
